// File: rtl/cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_sequencer
//  Purpose  : Stores a small table of router configuration entries and, once
//             started, replays entries 0..ii-1 cyclically for a programmed
//             number of iterations (or until stopped).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              : sole clock, rising edge
//    reset            : asynchronous, active-low reset
//    i__cfg_wr_en     : configuration write strobe
//    i__cfg_wr_addr   : entry index to write
//    i__cfg_wr_data   : entry {regWEN[3:0], regbypass[3:0], xbar_sel}
//    i__start         : start-execution request (honoured in IDLE only)
//    i__stop          : abort request (wins over i__start)
//    i__ii            : initiation interval = number of active entries
//    i__iter_count    : iterations to run, 0 = run until stopped
//    o__sram_xbar_sel : per-output one-hot input select to the router
//    o__regbypass     : router register bypass per direction
//    o__regWEN        : router register write enable per direction
//    o__pc            : index of the entry currently driven
//    o__busy          : high while replaying entries
//    o__done          : one-cycle pulse after the final iteration
//    o__wr_err        : one-cycle pulse for a rejected write
//    o__sel_err       : sticky, a stored entry has a non-one-hot select row
// ============================================================================
module cfg_sequencer #(
   parameter int CFG_DEPTH        = 16,
   parameter int NUM_INPUT_PORTS  = 6,
   parameter int NUM_OUTPUT_PORTS = 7
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        i__cfg_wr_en,
   input  logic [$clog2(CFG_DEPTH):0]                  i__cfg_wr_addr,
   input  logic [49:0]                                 i__cfg_wr_data,
   input  logic                                        i__start,
   input  logic                                        i__stop,
   input  logic [$clog2(CFG_DEPTH):0]                  i__ii,
   input  logic [15:0]                                 i__iter_count,
   output logic [NUM_INPUT_PORTS*NUM_OUTPUT_PORTS-1:0] o__sram_xbar_sel,
   output logic [3:0]                                  o__regbypass,
   output logic [3:0]                                  o__regWEN,
   output logic [$clog2(CFG_DEPTH)-1:0]                o__pc,
   output logic                                        o__busy,
   output logic                                        o__done,
   output logic                                        o__wr_err,
   output logic                                        o__sel_err
);

   localparam int c_aw    = $clog2(CFG_DEPTH) + 1;
   localparam int c_pw    = $clog2(CFG_DEPTH);
   localparam int c_sel_w = NUM_INPUT_PORTS * NUM_OUTPUT_PORTS;
   localparam logic [c_aw-1:0] c_depth = c_aw'(CFG_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                  r_state;
   logic [49:0]             r_cfg_mem [CFG_DEPTH];
   logic [c_pw-1:0]         r_pc;
   logic [c_aw-1:0]         r_ii;
   logic [15:0]             r_iter_target;
   logic [15:0]             r_iter_cnt;
   logic [c_sel_w-1:0]      r_xbar_sel;
   logic [3:0]              r_regbypass;
   logic [3:0]              r_regwen;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_wr_err;
   logic                    r_sel_err;

   logic                    w_wr_ok;
   logic                    w_wr_bad;
   logic [c_pw-1:0]         w_wr_idx;
   logic [NUM_OUTPUT_PORTS-1:0] w_row_multi;
   logic                    w_sel_bad;
   logic [c_aw-1:0]         w_ii_clamped;
   logic                    w_start_ok;
   logic                    w_wrap;
   logic [15:0]             w_iter_next;
   logic                    w_last;
   logic [c_pw-1:0]         w_next_pc;
   logic [c_pw-1:0]         w_fetch_idx;
   logic [49:0]             w_fetch;

   // Writes are accepted whenever the table is not being replayed.
   assign w_wr_ok  = i__cfg_wr_en && (r_state != S_RUN) && (i__cfg_wr_addr < c_depth);
   assign w_wr_bad = i__cfg_wr_en && !w_wr_ok;
   assign w_wr_idx = i__cfg_wr_addr[c_pw-1:0];

   // A select row is malformed when more than one bit is set: x & (x-1)
   // clears the lowest set bit, so anything left over means a second bit.
   for (genvar j = 0; j < NUM_OUTPUT_PORTS; j++) begin : g_row
      logic [NUM_INPUT_PORTS-1:0] w_row;
      assign w_row          = i__cfg_wr_data[j*NUM_INPUT_PORTS +: NUM_INPUT_PORTS];
      assign w_row_multi[j] = |(w_row & (w_row - NUM_INPUT_PORTS'(1)));
   end
   assign w_sel_bad = w_wr_ok && (|w_row_multi);

   always_comb begin
      w_ii_clamped = i__ii;
      if (i__ii == '0)
         w_ii_clamped = c_aw'(1);
      else if (i__ii > c_depth)
         w_ii_clamped = c_depth;
   end

   assign w_start_ok  = (r_state == S_IDLE) && i__start && !i__stop;
   assign w_wrap      = ({1'b0, r_pc} == (r_ii - c_aw'(1)));
   assign w_iter_next = r_iter_cnt + 16'd1;
   assign w_last      = w_wrap && (r_iter_target != 16'd0) && (w_iter_next == r_iter_target);
   assign w_next_pc   = w_wrap ? '0 : (r_pc + c_pw'(1));

   // The entry for the *next* pc is fetched combinationally and registered
   // together with o__pc, so the outputs carry no extra latency. A write
   // landing on the fetched index in the same cycle is forwarded so a
   // start issued alongside a write to entry 0 sees the new data.
   assign w_fetch_idx = w_start_ok ? '0 : w_next_pc;
   assign w_fetch     = (w_wr_ok && (w_wr_idx == w_fetch_idx)) ? i__cfg_wr_data
                                                               : r_cfg_mem[w_fetch_idx];

   // Configuration storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (w_wr_ok)
         r_cfg_mem[w_wr_idx] <= i__cfg_wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_pc          <= '0;
         r_ii          <= c_aw'(1);
         r_iter_target <= '0;
         r_iter_cnt    <= '0;
         r_xbar_sel    <= '0;
         r_regbypass   <= '0;
         r_regwen      <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_wr_err      <= 1'b0;
         r_sel_err     <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_wr_err <= w_wr_bad;

         // A malformed write in the same cycle as a start still flags.
         if (w_sel_bad)
            r_sel_err <= 1'b1;
         else if (w_start_ok)
            r_sel_err <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_state       <= S_RUN;
                  r_ii          <= w_ii_clamped;
                  r_iter_target <= i__iter_count;
                  r_iter_cnt    <= '0;
                  r_pc          <= '0;
                  r_xbar_sel    <= w_fetch[c_sel_w-1:0];
                  r_regbypass   <= w_fetch[c_sel_w+3:c_sel_w];
                  r_regwen      <= w_fetch[c_sel_w+7:c_sel_w+4];
                  r_busy        <= 1'b1;
               end
            end

            S_RUN: begin
               if (i__stop || w_last) begin
                  r_state     <= i__stop ? S_IDLE : S_DONE;
                  r_done      <= !i__stop;
                  r_pc        <= '0;
                  r_xbar_sel  <= '0;
                  r_regbypass <= '0;
                  r_regwen    <= '0;
                  r_busy      <= 1'b0;
                  if (!i__stop)
                     r_iter_cnt <= w_iter_next;
               end else begin
                  r_pc        <= w_next_pc;
                  r_xbar_sel  <= w_fetch[c_sel_w-1:0];
                  r_regbypass <= w_fetch[c_sel_w+3:c_sel_w];
                  r_regwen    <= w_fetch[c_sel_w+7:c_sel_w+4];
                  // Free-running count wraps silently when no target is set.
                  if (w_wrap)
                     r_iter_cnt <= w_iter_next;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state     <= S_IDLE;
               r_pc        <= '0;
               r_xbar_sel  <= '0;
               r_regbypass <= '0;
               r_regwen    <= '0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign o__sram_xbar_sel = r_xbar_sel;
   assign o__regbypass     = r_regbypass;
   assign o__regWEN        = r_regwen;
   assign o__pc            = r_pc;
   assign o__busy          = r_busy;
   assign o__done          = r_done;
   assign o__wr_err        = r_wr_err;
   assign o__sel_err       = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cfg_sequencer
//  Purpose  : Directed self-checking bench for cfg_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cfg_sequencer;

   localparam int CFG_DEPTH = 16;
   localparam int AW        = $clog2(CFG_DEPTH) + 1;
   localparam int PW        = $clog2(CFG_DEPTH);

   logic          clk;
   logic          reset;
   logic          i__cfg_wr_en;
   logic [AW-1:0] i__cfg_wr_addr;
   logic [49:0]   i__cfg_wr_data;
   logic          i__start;
   logic          i__stop;
   logic [AW-1:0] i__ii;
   logic [15:0]   i__iter_count;
   logic [41:0]   o__sram_xbar_sel;
   logic [3:0]    o__regbypass;
   logic [3:0]    o__regWEN;
   logic [PW-1:0] o__pc;
   logic          o__busy;
   logic          o__done;
   logic          o__wr_err;
   logic          o__sel_err;

   int checks   = 0;
   int failures = 0;

   cfg_sequencer #(
      .CFG_DEPTH        (CFG_DEPTH),
      .NUM_INPUT_PORTS  (6),
      .NUM_OUTPUT_PORTS (7)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .i__cfg_wr_en     (i__cfg_wr_en),
      .i__cfg_wr_addr   (i__cfg_wr_addr),
      .i__cfg_wr_data   (i__cfg_wr_data),
      .i__start         (i__start),
      .i__stop          (i__stop),
      .i__ii            (i__ii),
      .i__iter_count    (i__iter_count),
      .o__sram_xbar_sel (o__sram_xbar_sel),
      .o__regbypass     (o__regbypass),
      .o__regWEN        (o__regWEN),
      .o__pc            (o__pc),
      .o__busy          (o__busy),
      .o__done          (o__done),
      .o__wr_err        (o__wr_err),
      .o__sel_err       (o__sel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Entry with a single select bit: output row 'row', input 'bitn'.
   function automatic logic [49:0] ent(input int row, input int bitn,
                                       input logic [3:0] byp, input logic [3:0] wen);
      logic [49:0] d;
      d              = '0;
      d[row*6+bitn]  = 1'b1;
      d[45:42]       = byp;
      d[49:46]       = wen;
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [49:0] e, input int pc, input logic busy);
      logic [41:0] sel;
      logic [3:0]  byp;
      logic [3:0]  wen;
      sel = e[41:0];
      byp = e[45:42];
      wen = e[49:46];
      chk({tag, ".sel"},  64'(o__sram_xbar_sel), 64'(sel));
      chk({tag, ".byp"},  64'(o__regbypass),     64'(byp));
      chk({tag, ".wen"},  64'(o__regWEN),        64'(wen));
      chk({tag, ".pc"},   64'(o__pc),            64'(pc));
      chk({tag, ".busy"}, 64'(o__busy),          64'(busy));
   endtask

   task automatic wr(input int addr, input logic [49:0] data);
      i__cfg_wr_en   = 1'b1;
      i__cfg_wr_addr = AW'(addr);
      i__cfg_wr_data = data;
      tick();
      i__cfg_wr_en   = 1'b0;
   endtask

   task automatic start(input int ii, input int iter);
      i__ii         = AW'(ii);
      i__iter_count = 16'(iter);
      i__start      = 1'b1;
      tick();
      i__start      = 1'b0;
   endtask

   logic [49:0] e0, e1, e2, e3, e4, e5, ebad;
   logic [49:0] tbl [4];

   initial begin
      e0   = ent(0, 0, 4'b0010, 4'b0001);
      e1   = ent(1, 1, 4'b0100, 4'b0010);
      e2   = ent(6, 5, 4'b1000, 4'b0100);
      e3   = ent(3, 2, 4'b0001, 4'b1000);
      e4   = ent(2, 4, 4'b1111, 4'b0011);
      e5   = ent(4, 3, 4'b0110, 4'b1001);
      ebad = '0;
      ebad[1:0]   = 2'b11;
      ebad[45:42] = 4'b0101;
      tbl[0] = e0; tbl[1] = e1; tbl[2] = e2; tbl[3] = e3;

      reset          = 1'b0;
      i__cfg_wr_en   = 1'b0;
      i__cfg_wr_addr = '0;
      i__cfg_wr_data = '0;
      i__start       = 1'b0;
      i__stop        = 1'b0;
      i__ii          = '0;
      i__iter_count  = '0;

      // Reset state
      repeat (2) tick();
      chk_out("rst", '0, 0, 1'b0);
      chk("rst.done",    64'(o__done),    64'(0));
      chk("rst.wr_err",  64'(o__wr_err),  64'(0));
      chk("rst.sel_err", 64'(o__sel_err), 64'(0));
      reset = 1'b1;
      tick();

      // Load table
      wr(0, e0); chk("wr0.wr_err", 64'(o__wr_err), 64'(0));
      wr(1, e1);
      wr(2, e2);
      wr(3, e3);

      // ii=3, iter=2: 0,1,2,0,1,2 then one done cycle
      start(3, 2);
      for (int k = 0; k < 6; k++) begin
         chk_out($sformatf("t1.k%0d", k), tbl[k % 3], k % 3, 1'b1);
         chk($sformatf("t1.k%0d.done", k), 64'(o__done), 64'(0));
         tick();
      end
      chk("t1.done", 64'(o__done), 64'(1));
      chk_out("t1.done", '0, 0, 1'b0);
      tick();
      chk("t1.after.done", 64'(o__done), 64'(0));
      chk_out("t1.after", '0, 0, 1'b0);

      // ii=0 behaves as 1: entry 0 held three cycles
      start(0, 3);
      for (int k = 0; k < 3; k++) begin
         chk_out($sformatf("t2.k%0d", k), e0, 0, 1'b1);
         tick();
      end
      chk("t2.done", 64'(o__done), 64'(1));
      tick();
      chk("t2.after.done", 64'(o__done), 64'(0));

      // Free run ii=4, rejected write mid-run, then start+stop abort
      start(4, 0);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) tick();
         chk_out($sformatf("t3.k%0d", k), tbl[k % 4], k % 4, 1'b1);
      end
      i__cfg_wr_en   = 1'b1;
      i__cfg_wr_addr = AW'(1);
      i__cfg_wr_data = e5;
      tick();
      i__cfg_wr_en   = 1'b0;
      chk("t3.wr_err", 64'(o__wr_err), 64'(1));
      chk("t3.pc10",   64'(o__pc),     64'(2));
      tick();
      chk("t3.wr_err.clr", 64'(o__wr_err), 64'(0));
      tick();
      tick();
      chk_out("t3.e1_unchanged", e1, 1, 1'b1);
      i__start = 1'b1;
      i__stop  = 1'b1;
      tick();
      i__start = 1'b0;
      i__stop  = 1'b0;
      chk_out("t3.stop", '0, 0, 1'b0);
      chk("t3.stop.done", 64'(o__done), 64'(0));
      tick();
      chk("t3.stop2.done", 64'(o__done), 64'(0));
      chk("t3.stop2.busy", 64'(o__busy), 64'(0));

      // start+stop in IDLE: stop wins
      i__start = 1'b1;
      i__stop  = 1'b1;
      tick();
      i__start = 1'b0;
      i__stop  = 1'b0;
      chk("idle_ss.busy", 64'(o__busy), 64'(0));

      // Out-of-range write address
      wr(CFG_DEPTH, e5);
      chk("oor.wr_err", 64'(o__wr_err), 64'(1));
      tick();
      chk("oor.wr_err.clr", 64'(o__wr_err), 64'(0));

      // Multi-hot select row: sticky until accepted start
      wr(5, ebad);
      chk("sel.err.set",    64'(o__sel_err), 64'(1));
      chk("sel.wr_err",     64'(o__wr_err),  64'(0));
      tick();
      tick();
      chk("sel.err.sticky", 64'(o__sel_err), 64'(1));
      start(1, 1);
      chk("sel.err.clr", 64'(o__sel_err), 64'(0));
      chk_out("sel.run", e0, 0, 1'b1);
      tick();
      chk("sel.done", 64'(o__done), 64'(1));
      tick();

      // Asynchronous reset mid-run at pc=2
      start(3, 0);
      chk("rr.pc0", 64'(o__pc), 64'(0));
      tick();
      tick();
      chk_out("rr.pc2", e2, 2, 1'b1);
      reset = 1'b0;
      #1;
      chk_out("rr.async", '0, 0, 1'b0);
      chk("rr.async.done", 64'(o__done), 64'(0));
      tick();
      chk("rr.held.done", 64'(o__done), 64'(0));
      chk("rr.held.busy", 64'(o__busy), 64'(0));
      reset = 1'b1;
      tick();
      chk("rr.release.busy", 64'(o__busy), 64'(0));
      start(3, 1);
      for (int k = 0; k < 3; k++) begin
         chk_out($sformatf("rr.replay.k%0d", k), tbl[k], k, 1'b1);
         tick();
      end
      chk("rr.replay.done", 64'(o__done), 64'(1));
      tick();

      // Write entry 0 and start in the same cycle
      i__cfg_wr_en   = 1'b1;
      i__cfg_wr_addr = '0;
      i__cfg_wr_data = e4;
      start(1, 1);
      i__cfg_wr_en   = 1'b0;
      chk_out("wrs.bypass", e4, 0, 1'b1);
      tick();
      chk("wrs.done", 64'(o__done), 64'(1));
      tick();

      // ii above depth is clamped to CFG_DEPTH
      start(31, 1);
      for (int k = 0; k < CFG_DEPTH; k++) begin
         chk($sformatf("clamp.pc%0d", k), 64'(o__pc), 64'(k));
         tick();
      end
      chk("clamp.done", 64'(o__done), 64'(1));
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cfg_sequencer.md
CFG_SEQUENCER -- requirements
Module: cfg_sequencer

Interface
REQ-001 SHALL have parameter CFG_DEPTH, default 16: number of configuration entries.
REQ-002 SHALL have parameter NUM_INPUT_PORTS, default 6, and NUM_OUTPUT_PORTS, default 7: crossbar dimensions.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i__cfg_wr_en  input  1  configuration write strobe.
REQ-006 SHALL have port i__cfg_wr_addr  input  $clog2(CFG_DEPTH)+1  write entry index.
REQ-007 SHALL have port i__cfg_wr_data  input  50  entry: bits[41:0] = xbar select, row j (output port) = bits[6j+5:6j]; bits[45:42] = regbypass; bits[49:46] = regWEN.
REQ-008 SHALL have port i__start  input  1  start-execution request.
REQ-009 SHALL have port i__stop  input  1  abort request.
REQ-010 SHALL have port i__ii  input  $clog2(CFG_DEPTH)+1  initiation interval (active entry count).
REQ-011 SHALL have port i__iter_count  input  16  loop iterations; 0 = run until stopped.
REQ-012 SHALL have port o__sram_xbar_sel  output  NUM_INPUT_PORTS x NUM_OUTPUT_PORTS  per-output one-hot input select to the router.
REQ-013 SHALL have port o__regbypass  output  4  router register bypass per direction.
REQ-014 SHALL have port o__regWEN  output  4  router register write enable per direction.
REQ-015 SHALL have port o__pc  output  $clog2(CFG_DEPTH)  index of entry currently driven.
REQ-016 SHALL have ports o__busy, o__done, o__wr_err, o__sel_err  output  1 each  status.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-018 IDLE: i__start=1 and i__stop=0 -> RUN at next edge, pc=0, outputs = entry 0; i__ii and i__iter_count latched at that edge.
REQ-019 Latched ii: 0 SHALL be treated as 1; values > CFG_DEPTH SHALL be clamped to CFG_DEPTH.
REQ-020 RUN: each edge pc advances by 1; at pc==ii-1 it wraps to 0 and the iteration counter increments.
REQ-021 RUN: outputs SHALL equal the entry at pc in the same cycle that o__pc shows it (zero added latency).
REQ-022 RUN: when wrapping with completed iterations == latched iter_count (non-zero) -> DONE; outputs forced idle.
REQ-023 DONE SHALL last exactly one cycle with o__done=1, then go to IDLE.
REQ-024 i__stop=1 in RUN -> IDLE at next edge, outputs idle, o__done stays 0; i__stop wins over i__start in the same cycle.
REQ-025 i__start in RUN or DONE SHALL be ignored.
REQ-026 Idle output values: xbar select all 0, regbypass 4'b0000, regWEN 4'b0000, pc 0.
REQ-027 o__busy SHALL be 1 exactly in RUN.
REQ-028 Writes SHALL commit only in IDLE or DONE with addr < CFG_DEPTH; otherwise ignored and o__wr_err pulses 1 for one cycle.
REQ-029 A committed entry with any select row having >1 bit set SHALL still be stored and SHALL set sticky o__sel_err; accepted i__start clears it.
REQ-030 Writing an entry and starting in the same cycle: the write SHALL commit and entry 0 SHALL reflect new data if addr==0.
REQ-031 Iteration counter SHALL be 16 bits; with iter_count=0 it may wrap silently and RUN continues.

Reset
REQ-032 Reset low SHALL immediately force IDLE, all outputs to idle values, o__done/o__wr_err/o__sel_err = 0, iteration counter 0.
REQ-033 Configuration memory contents SHALL be unaffected by reset.
REQ-034 Reset asserted mid-RUN SHALL abort without an o__done pulse; release requires a new i__start.

Verification
REQ-035 Load entries 0..2 with distinct one-hot patterns, ii=3, iter=2, start -> entries 0,1,2,0,1,2 on 6 consecutive cycles, o__pc 0,1,2,0,1,2, then o__done=1 for 1 cycle, then idle outputs.
REQ-036 ii=0, iter=3 -> entry 0 held 3 cycles, then o__done pulse.
REQ-037 iter=0, ii=4, run 10 cycles, assert start+stop together -> next cycle IDLE, outputs zero, no done.
REQ-038 Write during RUN (addr 1) -> o__wr_err pulse; entry 1 unchanged on next pass; write addr=CFG_DEPTH in IDLE -> o__wr_err pulse.
REQ-039 Write entry with row 0 = 6'b000011 -> o__sel_err=1, persists until next accepted start.
REQ-040 Reset low at pc=2 in RUN -> outputs zero immediately; after release, start replays stored entries unchanged.
